vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Passive VGA sink that samples the game's own `hsync`/`vsync`/RGB outputs on the pixel clock and rebuilds pixel coordinates from the sync edges. It checks timing against 640x480@60 and declares lock after consecutive good frames. Once locked it emits per-pixel data and per-frame statistics. It sits beside the VGA output as the receiving end of that interface and is used for on-board self-test: the LED bank shows lock and error state, and the simulation bench uses it to check drawn frames.

## Interface
Parameters:
- `H_TOTAL`, 800: clocks per line
- `H_SYNC`, 96: hsync low width, in clocks
- `H_BP`, 48: horizontal back porch
- `H_ACTIVE`, 640: visible pixels per line
- `V_TOTAL`, 525: lines per frame
- `V_SYNC`, 2: vsync low width, in lines
- `V_BP`, 33: vertical back porch
- `V_ACTIVE`, 480: visible lines
- `LOCK_FRAMES`, 2: consecutive good frames needed to lock

Ports:
- `vga_clk` input 1: 25 MHz pixel clock, the same clock that drives the VGA generator
- `reset` input 1: asynchronous, active-low
- `hsync_in` input 1: horizontal sync, active low
- `vsync_in` input 1: vertical sync, active low
- `rgb_in` input 6: {red[1:0], green[1:0], blue[1:0]}
- `locked` output 1: timing lock
- `pix_valid` output 1: visible pixel present on `pix_*`
- `pix_x` output 10: visible column, 0..639
- `pix_y` output 10: visible row, 0..479
- `pix_rgb` output 6: registered pixel data
- `frame_done` output 1: one-cycle pulse at every vsync falling edge
- `frame_lit` output 19: non-black visible pixels in the last frame
- `err_count` output 8: bad frames seen while locked, saturating

## Operation
Input stage:
- `hsync_in`, `vsync_in` and `rgb_in` are registered once; the registered copies are `hs`, `vs`, `rgb`.
- A falling edge (`hs_fall` / `vs_fall`) is the previous sample = 1 and the current sample = 0.

Counters:
- `h_cnt` (11 bits):
  - set to 0 on `hs_fall`, otherwise increments;
  - saturates at 2047.
- `hs_low` counts `hs` = 0 cycles since `hs_fall`.
- `v_cnt` (10 bits):
  - set to 0 on `vs_fall`; this wins if `hs_fall` occurs in the same cycle;
  - otherwise increments on `hs_fall`;
  - saturates at 1023.

Line and frame checks:
- A line is good when, at the next `hs_fall`:
  - previous `h_cnt` + 1 == `H_TOTAL`;
  - the hsync low width equals `H_SYNC`.
- A line failing either check sets sticky `frame_err`.
- A frame is good when, at `vs_fall`:
  - previous `v_cnt` + 1 == `V_TOTAL`;
  - the vsync low width equals `V_SYNC` lines;
  - `frame_err` = 0.
- `frame_err` clears at every `vs_fall`.

State machine (`SEARCH`, `TRACK`, `LOCKED`):
- `SEARCH`: the first `vs_fall` moves to `TRACK` with `good` = 0. That first partial frame is never judged.
- `TRACK`:
  - a good frame increments `good`; reaching `LOCK_FRAMES` moves to `LOCKED`;
  - a bad frame clears `good` and stays in `TRACK`.
- `LOCKED`:
  - a bad frame moves to `TRACK` with `good` = 0 and increments `err_count`, saturating at 255.
- Any state: `h_cnt` reaching 2047 (no hsync) moves to `SEARCH` and clears `good`.

Visible region and pixel output:
- The visible region is `h_cnt` in [`H_SYNC`+`H_BP`, +`H_ACTIVE`) and `v_cnt` in [`V_SYNC`+`V_BP`, +`V_ACTIVE`).
- `pix_valid` = `locked` AND visible region.
- `pix_x` = `h_cnt` − 144 and `pix_y` = `v_cnt` − 35 at the default parameters.
- `pix_x`, `pix_y` and `pix_rgb` update only when `pix_valid` = 1 and hold otherwise.

Frame statistics:
- The lit accumulator increments on every visible pixel with `rgb` != 0, counted regardless of lock.
- At `vs_fall`, the accumulator value is copied to `frame_lit` and the accumulator clears. If a lit visible pixel coincides with that edge, it is counted into the new frame.
- `frame_done` pulses on every `vs_fall` in every state, including `SEARCH`.

## Timing
- Reset values: all outputs 0; state `SEARCH`; all counters 0; input registers 1 (idle sync).
- Reset is asynchronous on assertion; release is sampled on the next `vga_clk` edge.
- Latency: pin → `pix_*`, `pix_valid` = 2 clocks.
- Latency: pin edge → `frame_done`, `locked` change, `frame_lit` update = 2 clocks.
- `locked` changes only in the cycle after a `vs_fall`, or after the no-hsync timeout.
- Reset mid-frame: the next frame after release is a partial frame and is never judged; earliest lock is at the (`LOCK_FRAMES`+1)-th `vs_fall` after release.

## Test plan
- Ideal 640x480 stream, all-black RGB, from reset → `locked` = 1 two clocks after the 3rd `vs_fall`; `frame_lit` = 0; `err_count` = 0.
- Locked, one frame with a single 799-clock line → `locked` drops at that frame's `vs_fall`; `err_count` = 1; relocks after 2 further good frames.
- Locked, RGB = 6'h3F only at `pix_x` = 0 and 639 on every row → `frame_lit` = 960; `pix_valid` high for exactly 640 clocks per visible line.
- First visible pixel (`h_cnt` 144, `v_cnt` 35) driven with 6'h2A → 2 clocks later `pix_valid` = 1, `pix_x` = 0, `pix_y` = 0, `pix_rgb` = 6'h2A.
- Locked, hsync held high for 2100 clocks → state `SEARCH`, `locked` = 0, `err_count` unchanged.
- `reset` asserted low mid-frame while locked → all outputs 0 immediately; after release, lock at the 3rd `vs_fall`.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: passive VGA sink. Samples hsync/vsync/rgb on the pixel clock, rebuilds pixel
// coordinates from the sync edges, checks line/frame timing and declares lock after a run of good
// frames. While locked it emits per-pixel data; per-frame lit-pixel statistics are always kept.
//
// Ports:
//   vga_clk     pixel clock (same clock as the VGA generator)
//   reset       asynchronous active-low reset
//   hsync_in    horizontal sync, active low
//   vsync_in    vertical sync, active low
//   rgb_in      {red[1:0], green[1:0], blue[1:0]}
//   locked      timing lock
//   pix_valid   visible pixel present on pix_x/pix_y/pix_rgb
//   pix_x       visible column
//   pix_y       visible row
//   pix_rgb     registered pixel data
//   frame_done  one-cycle pulse per vsync falling edge
//   frame_lit   non-black visible pixels in the last frame
//   err_count   bad frames seen while locked, saturating
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [5:0]  rgb_in,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_done,
  output logic [18:0] frame_lit,
  output logic [7:0]  err_count
);

  localparam logic [10:0] HStart = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HEnd   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] HLast  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HSyncW = 11'(H_SYNC);
  localparam logic [9:0]  VStart = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VEnd   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  VLast  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VSyncW = 10'(V_SYNC);
  localparam logic [7:0]  LockN  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

  // Input stage
  logic       hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [5:0] rgb_q;
  logic       hs_fall, vs_fall;

  // Timing counters
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] hs_low_q, hs_low_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  vs_low_q, vs_low_d;
  logic        frame_err_q, frame_err_d;
  logic        line_bad, frame_good, timeout;

  // Lock state machine
  state_e      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  err_q, err_d;
  logic        locked_q;

  // Pixel and statistics
  logic        vis_d, pix_valid_d, lit_inc;
  logic        pix_valid_q, frame_done_q;
  logic [9:0]  pix_x_q, pix_y_q, pix_x_d, pix_y_d;
  logic [5:0]  pix_rgb_q;
  logic [18:0] lit_q, lit_d, frame_lit_q;

  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;

  // The line that ends on this hs_fall is judged against its length and sync width.
  assign line_bad = hs_fall & ((h_cnt_q != HLast) | (hs_low_q != HSyncW));

  // A line ending on the same cycle as vs_fall still belongs to the frame being judged.
  assign frame_good = (v_cnt_q == VLast) & (vs_low_q == VSyncW) & ~frame_err_q & ~line_bad;

  // A saturated h_cnt is cleared by a coinciding hs_fall, so that cycle is not a timeout.
  assign timeout = (h_cnt_q == 11'h7FF) & ~hs_fall;

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_fall) begin
      h_cnt_d = 11'd0;
    end else if (h_cnt_q != 11'h7FF) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end

    hs_low_d = hs_low_q;
    if (hs_fall) begin
      hs_low_d = 11'd1;
    end else if (!hs_q && hs_low_q != 11'h7FF) begin
      hs_low_d = hs_low_q + 11'd1;
    end

    v_cnt_d = v_cnt_q;
    if (vs_fall) begin
      v_cnt_d = 10'd0;
    end else if (hs_fall && v_cnt_q != 10'h3FF) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    // Vsync width in lines: the line starting at vs_fall plus each later line start while low.
    vs_low_d = vs_low_q;
    if (vs_fall) begin
      vs_low_d = 10'd1;
    end else if (hs_fall && !vs_q && vs_low_q != 10'h3FF) begin
      vs_low_d = vs_low_q + 10'd1;
    end

    frame_err_d = vs_fall ? 1'b0 : (frame_err_q | line_bad);
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    if (timeout) begin
      state_d = StSearch;
      good_d  = 8'd0;
    end else if (vs_fall) begin
      case (state_q)
        StSearch: begin
          // The first frame seen is partial and never judged.
          state_d = StTrack;
          good_d  = 8'd0;
        end
        StTrack: begin
          if (!frame_good) begin
            good_d = 8'd0;
          end else if (good_q + 8'd1 >= LockN) begin
            state_d = StLocked;
            good_d  = 8'd0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        StLocked: begin
          if (!frame_good) begin
            state_d = StTrack;
            good_d  = 8'd0;
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = StSearch;
          good_d  = 8'd0;
        end
      endcase
    end
  end

  // Pixel path works on the counter values being loaded this edge, which line up with rgb_q.
  always_comb begin
    vis_d       = (h_cnt_d >= HStart) && (h_cnt_d < HEnd) && (v_cnt_d >= VStart) && (v_cnt_d < VEnd);
    pix_valid_d = locked_q & vis_d;
    pix_x_d     = 10'(h_cnt_d - HStart);
    pix_y_d     = v_cnt_d - VStart;
    lit_inc     = vis_d & (rgb_q != 6'd0);
    // A lit pixel coinciding with vs_fall is counted into the new frame.
    lit_d       = vs_fall ? {18'd0, lit_inc} : (lit_q + {18'd0, lit_inc});
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      hs_q         <= 1'b1;
      hs_prev_q    <= 1'b1;
      vs_q         <= 1'b1;
      vs_prev_q    <= 1'b1;
      rgb_q        <= 6'd0;
      h_cnt_q      <= 11'd0;
      hs_low_q     <= 11'd0;
      v_cnt_q      <= 10'd0;
      vs_low_q     <= 10'd0;
      frame_err_q  <= 1'b0;
      state_q      <= StSearch;
      good_q       <= 8'd0;
      err_q        <= 8'd0;
      locked_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 10'd0;
      pix_y_q      <= 10'd0;
      pix_rgb_q    <= 6'd0;
      frame_done_q <= 1'b0;
      lit_q        <= 19'd0;
      frame_lit_q  <= 19'd0;
    end else begin
      hs_q         <= hsync_in;
      hs_prev_q    <= hs_q;
      vs_q         <= vsync_in;
      vs_prev_q    <= vs_q;
      rgb_q        <= rgb_in;
      h_cnt_q      <= h_cnt_d;
      hs_low_q     <= hs_low_d;
      v_cnt_q      <= v_cnt_d;
      vs_low_q     <= vs_low_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      good_q       <= good_d;
      err_q        <= err_d;
      locked_q     <= (state_d == StLocked);
      pix_valid_q  <= pix_valid_d;
      if (pix_valid_d) begin
        pix_x_q   <= pix_x_d;
        pix_y_q   <= pix_y_d;
        pix_rgb_q <= rgb_q;
      end
      frame_done_q <= vs_fall;
      lit_q        <= lit_d;
      if (vs_fall) begin
        frame_lit_q <= lit_q;
      end
    end
  end

  assign locked     = locked_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign frame_done = frame_done_q;
  assign frame_lit  = frame_lit_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a shrunken raster (20x10 clocks/lines per frame).
module tb_vga_sync_receiver;

  localparam int HT  = 20;
  localparam int HSW = 3;
  localparam int HBP = 2;
  localparam int HA  = 12;
  localparam int VT  = 10;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int VA  = 5;
  localparam int HS0 = HSW + HBP;
  localparam int VS0 = VSW + VBP;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [5:0]  rgb_in = 6'd0;
  logic        locked, pix_valid, frame_done;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [18:0] frame_lit;
  logic [7:0]  err_count;

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_BP(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_BP(VBP), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .rgb_in     (rgb_in),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .frame_lit  (frame_lit),
    .err_count  (err_count)
  );

  always #20 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {int cyc; int x; int y; int rgb;} pix_t;
  typedef struct {int cyc; int lit; int lk; int err;} fd_t;

  pix_t pix_q[$];
  fd_t  fd_q[$];
  int   checks = 0;
  int   failures = 0;
  int   acc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expected item whenever the DUT presents a pixel or a frame pulse.
  always @(negedge vga_clk) begin : monitor
    pix_t p;
    fd_t  f;
    if (reset) begin
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pix_unexpected: got pix_valid=1 x=%0d y=%0d expected no pixel (cycle %0d)",
                   pix_x, pix_y, cyc);
        end else begin
          p = pix_q.pop_front();
          check("pix_latency", cyc, p.cyc);
          check("pix_x", int'(pix_x), p.x);
          check("pix_y", int'(pix_y), p.y);
          check("pix_rgb", int'(pix_rgb), p.rgb);
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_done_unexpected: got frame_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          f = fd_q.pop_front();
          check("frame_done_latency", cyc, f.cyc);
          check("frame_lit", int'(frame_lit), f.lit);
          check("locked_at_vs", int'(locked), f.lk);
          check("err_count_at_vs", int'(err_count), f.err);
        end
      end
    end
  end

  function automatic logic [5:0] pat(input int mode, input int x, input int y);
    if (mode == 1 && (x == 0 || x == HA - 1)) return 6'h3F;
    if (mode == 2 && x == 0 && y == 0) return 6'h2A;
    return 6'h00;
  endfunction

  task automatic drive(input logic h, input logic v, input logic [5:0] c);
    @(negedge vga_clk);
    hsync_in = h;
    vsync_in = v;
    rgb_in   = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 6'd0);
  endtask

  // Lines first..last of a frame; lk/err are the values expected after this frame's vs_fall.
  task automatic send_lines(input int first, input int last, input int mode, input int lk,
                            input int err, input int short_line);
    for (int l = first; l <= last; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        logic       vis;
        logic [5:0] c;
        vis = (h >= HS0) && (h < HS0 + HA) && (l >= VS0) && (l < VS0 + VA);
        c   = vis ? pat(mode, h - HS0, l - VS0) : 6'd0;
        drive(h >= HSW, l >= VSW, c);
        if (l == 0 && h == 0) begin
          fd_q.push_back('{cyc: cyc + 2, lit: acc, lk: lk, err: err});
          acc = 0;
        end
        if (vis) begin
          if (c != 6'd0) acc++;
          if (lk != 0) pix_q.push_back('{cyc: cyc + 2, x: h - HS0, y: l - VS0, rgb: int'(c)});
        end
      end
    end
  endtask

  task automatic send_frame(input int mode, input int lk, input int err, input int short_line);
    send_lines(0, VT - 1, mode, lk, err, short_line);
  endtask

  task automatic check_zero();
    check("rst_locked", int'(locked), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_pix_y", int'(pix_y), 0);
    check("rst_pix_rgb", int'(pix_rgb), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_lit", int'(frame_lit), 0);
    check("rst_err_count", int'(err_count), 0);
  endtask

  initial begin
    idle(3);
    check_zero();
    @(negedge vga_clk);
    reset = 1'b1;

    // Lock from reset on an ideal black stream: third vs_fall locks.
    send_frame(0, 0, 0, -1);
    send_frame(0, 0, 0, -1);
    send_frame(0, 1, 0, -1);
    // One short line while locked, then relock after two good frames.
    send_frame(0, 1, 0, 5);
    send_frame(0, 0, 1, -1);
    send_frame(0, 0, 1, -1);
    send_frame(1, 1, 1, -1);
    send_frame(2, 1, 1, -1);
    check("frame_lit_edge_columns", int'(frame_lit), 2 * VA);
    send_frame(0, 1, 1, -1);
    check("frame_lit_first_pixel", int'(frame_lit), 1);

    // No sync at all: timeout drops lock without counting an error.
    idle(2100);
    check("timeout_locked", int'(locked), 0);
    check("timeout_err_count", int'(err_count), 1);
    send_frame(0, 0, 1, -1);
    send_frame(0, 0, 1, -1);
    send_frame(0, 1, 1, -1);

    // Reset mid-frame while locked.
    send_lines(0, 6, 1, 1, 1, -1);
    check("pre_reset_locked", int'(locked), 1);
    check("pre_reset_pix_rgb", int'(pix_rgb), 6'h3F);
    @(negedge vga_clk);
    reset = 1'b0;
    #1;
    check_zero();
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b1;
    acc = 0;
    send_lines(7, VT - 1, 0, 0, 0, -1);
    send_frame(0, 0, 0, -1);
    send_frame(0, 0, 0, -1);
    send_frame(1, 1, 0, -1);
    idle(10);

    check("pix_queue_drained", pix_q.size(), 0);
    check("frame_queue_drained", fd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
